fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Write-side scheduler that shares one async FIFO write port among NREQ requesters.
- Each requester asks for a burst of req_len beats.
- The arbiter grants a burst only when the FIFO has room for all of it, then streams the burst with fifo_wr_en held continuously high.
- It always inserts a one-cycle wr_en-low gap after each burst. The FIFO publishes its write pointer on the falling edge of wr_en, so every burst becomes visible to the read side as one unit.
- Sits entirely in the wr_clk domain, between the producer blocks and the FIFO write interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; must match the FIFO WIDTH.
- PTRWIDTH, 4, FIFO pointer width; FIFO depth DEPTH = 2**PTRWIDTH.
- LENW, derived localparam = PTRWIDTH+1, width of each burst length field.

Ports:
- wr_clk  in  1  write clock.
- wr_rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until the burst completes.
- req_len  in  NREQ*LENW  burst length per requester; requester i occupies slice [i*LENW +: LENW].
- req_data  in  NREQ*WIDTH  current beat per requester; requester i occupies slice [i*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot grant, held for the whole burst.
- data_rd  out  NREQ  one-hot beat-accept strobe; requester advances to its next beat.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_data  out  WIDTH  to FIFO data_in.
- fifo_usedw  in  PTRWIDTH+1  from FIFO wr_usedw.
- fifo_full  in  1  from FIFO full.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, fifo_wr_en=0, data_rd=0, busy=0, fifo_data=0.
- Arithmetic:
  - free = DEPTH - fifo_usedw, computed at LENW width.
  - Requester i is eligible when req[i] && len_i != 0 && len_i <= free.
  - Requests with len=0 or len>DEPTH are never granted; they wait indefinitely.
- State IDLE:
  - Round-robin pick among eligible requesters, searching upward from rr_ptr with wrap.
  - On a pick at edge T: state<=BURST, grant<=onehot(i), beat_cnt<=len_i, rr_ptr<=(i+1) mod NREQ.
  - If nothing is eligible, remain in IDLE.
- State BURST:
  - fifo_wr_en = !fifo_full (combinational).
  - data_rd = grant & {NREQ{fifo_wr_en}}.
  - fifo_data = req_data slice of the granted requester.
  - Each cycle with fifo_wr_en=1: beat_cnt decrements.
  - When beat_cnt==1 and fifo_wr_en=1: state<=GAP.
  - Latency: the first beat is written in the cycle after the grant edge.
- State GAP:
  - Exactly one cycle with fifo_wr_en=0 and grant still held; then state<=IDLE and grant<=0.
  - The requester must drop req, or present a new len, by the first IDLE cycle.
  - A new grant is issued at the earliest at the edge that ends the first IDLE cycle.
- Full during BURST (only possible if fifo_usedw was stale):
  - fifo_wr_en drops, beat_cnt holds, and state holds until full clears.
  - Note: the low cycle causes an early pointer publish in the FIFO. This is accepted and is flagged as an error in the bench log only.
- Simultaneous events:
  - req[g] deasserted mid-burst is ignored; the burst completes with len beats.
  - Changes to other requesters' req/len during BURST have no effect until IDLE.
- Reset asserted mid-operation: everything returns immediately to reset values and the partial burst is abandoned.
- fifo_usedw is sampled only in IDLE. Its stale value overestimates occupancy, so the space check is conservative.

Optional Feature:
- Macro FWA_STRICT_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr logic is removed.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Decomposition:
- Package fwa_pkg:
  - state encoding constants IDLE=2'd0, BURST=2'd1, GAP=2'd2;
  - function onehot_rr_pick(eligible, rr_ptr) returning a one-hot vector.
- One sub-module, fwa_rr_pick: combinational round-robin picker taking eligible[NREQ] and rr_ptr, returning a one-hot grant.
- Top-level instance: single FSM plus beat counter plus data mux.

Test Plan:
- Single request, fifo_usedw=0: req[0]=1, len=5 → grant=0001 at T+1, fifo_wr_en high for exactly 5 cycles, data_rd[0] 5 pulses, 1 GAP cycle, busy=0 after.
- Space check, fifo_usedw=12 (DEPTH=16): req[1] len=5 → no grant; usedw drops to 11 → grant=0010 on the next IDLE edge.
- Fairness, all four requesters continuously active with len=2 and usedw=0 → grant order 0,1,2,3,0; each burst is 2 write cycles plus 1 gap.
- Full stall: BURST len=4, fifo_full forced high after beat 2 for 3 cycles → fifo_wr_en low for 3 cycles, then exactly 2 more beats; 4 data_rd total.
- Reset mid-burst: wr_rst_n low at beat 2 of len=6 → grant=0, fifo_wr_en=0, state IDLE within the same cycle; after release, rr_ptr=0.
- len=0 on req[2] with req[3] len=1 → req[2] never granted, req[3] granted; with FWA_STRICT_PRIO_EN, req[0] and req[1] both active → grant 0001 twice in a row.

Source files
------------

// File: rtl/fwa_pkg.sv
// ---------------------------------------------------------------------------
// fwa_pkg
// Shared definitions for the FIFO write-side arbiter (fifo_wr_arbiter).
//   fwa_state_t     : FSM state encoding (IDLE / BURST / GAP).
//   FWA_MAX_REQ     : widest requester vector the picker function handles.
//   onehot_rr_pick  : round-robin search over an eligibility vector,
//                     upward from rr_ptr with wrap at nreq, one-hot result.
// ---------------------------------------------------------------------------
package fwa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } fwa_state_t;

  localparam int FWA_MAX_REQ = 8;

  // Works on a fixed 8-bit vector so the package stays parameter-free;
  // callers zero-extend their eligibility vector and pass the real count.
  function automatic logic [FWA_MAX_REQ-1:0] onehot_rr_pick(
    input logic [FWA_MAX_REQ-1:0] eligible,
    input logic [2:0]             rr_ptr,
    input int                     nreq
  );
    logic [FWA_MAX_REQ-1:0] pick;
    logic                   found;
    int                     idx;
    logic [2:0]             idx3;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < FWA_MAX_REQ; k++) begin
      idx  = (int'(rr_ptr) + k) % nreq;
      idx3 = 3'(idx);
      if ((k < nreq) && !found && eligible[idx3]) begin
        pick[idx3] = 1'b1;
        found      = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fwa_rr_pick.sv
// ---------------------------------------------------------------------------
// fwa_rr_pick
// Combinational round-robin picker.
//   eligible [NREQ] : requesters that may be granted this cycle.
//   rr_ptr   [PW]   : index where the search starts (wraps at NREQ).
//   pick     [NREQ] : one-hot winner, all-zero when nothing is eligible.
// ---------------------------------------------------------------------------
module fwa_rr_pick
  import fwa_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] pick
);

  logic [FWA_MAX_REQ-1:0] elig8;
  logic [FWA_MAX_REQ-1:0] pick8;
  logic                   unused_pick_hi;

  always_comb begin
    elig8             = '0;
    elig8[NREQ-1:0]   = eligible;
  end

  assign pick8 = onehot_rr_pick(elig8, 3'(rr_ptr), NREQ);
  assign pick  = pick8[NREQ-1:0];

  // Bits above NREQ are always zero; folded here only to keep them referenced.
  assign unused_pick_hi = ^pick8;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one async-FIFO write port among NREQ requesters. A burst is granted
// only when the FIFO has room for all of it, is streamed with fifo_wr_en held
// high, and is always followed by one wr_en-low cycle so the FIFO publishes
// its write pointer once per burst.
//
// Ports:
//   wr_clk, wr_rst_n   write clock, asynchronous active-low reset
//   req        [NREQ]        level request per requester
//   req_len    [NREQ*LENW]   burst length, requester i at [i*LENW +: LENW]
//   req_data   [NREQ*WIDTH]  current beat, requester i at [i*WIDTH +: WIDTH]
//   grant      [NREQ]        one-hot, held for the whole burst (incl. gap)
//   data_rd    [NREQ]        one-hot beat-accept strobe
//   fifo_wr_en, fifo_data    to FIFO write side
//   fifo_usedw [PTRWIDTH+1], fifo_full   from FIFO write side
//   busy                     high whenever not IDLE
//
// Build option: define FWA_STRICT_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); otherwise round-robin.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fwa_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int PTRWIDTH = 4
) (
  input  logic                             wr_clk,
  input  logic                             wr_rst_n,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ*(PTRWIDTH+1)-1:0]     req_len,
  input  logic [NREQ*WIDTH-1:0]            req_data,
  output logic [NREQ-1:0]                  grant,
  output logic [NREQ-1:0]                  data_rd,
  output logic                             fifo_wr_en,
  output logic [WIDTH-1:0]                 fifo_data,
  input  logic [PTRWIDTH:0]                fifo_usedw,
  input  logic                             fifo_full,
  output logic                             busy
);

  localparam int LENW  = PTRWIDTH + 1;
  localparam int DEPTH = 2 ** PTRWIDTH;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  fwa_state_t        state;
  logic [LENW-1:0]   beat_cnt;
  logic [LENW-1:0]   free;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   pick;
  logic [LENW-1:0]   pick_len;
  logic [PW-1:0]     pick_ptr;

  // A stale usedw can only be higher than the true value, so this space
  // estimate errs on the safe side.
  assign free = LENW'(DEPTH) - fifo_usedw;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req[i] && (req_len[i*LENW +: LENW] != '0) &&
                    (req_len[i*LENW +: LENW] <= free);
    end
  end

`ifdef FWA_STRICT_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] next_rr;

  assign pick_ptr = rr_ptr;

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign next_rr = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
`endif

  fwa_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (pick_ptr),
    .pick     (pick)
  );

  always_comb begin
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_len = req_len[i*LENW +: LENW];
    end
  end

  // Write strobe follows fifo_full directly so a full FIFO stalls the burst
  // in the same cycle; grant is registered, so the data mux is glitch-free.
  assign fifo_wr_en = (state == BURST) && !fifo_full;
  assign data_rd    = grant & {NREQ{fifo_wr_en}};
  assign busy       = (state != IDLE);

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) fifo_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
`ifndef FWA_STRICT_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|pick) begin
            state    <= BURST;
            grant    <= pick;
            beat_cnt <= pick_len;
`ifndef FWA_STRICT_PRIO_EN
            rr_ptr   <= next_rr;
`endif
          end
        end
        BURST: begin
          // Length was latched at grant; req/len changes are ignored here.
          if (fifo_wr_en) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == LENW'(1)) state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
          grant <= '0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed scenarios followed by randomized traffic; every cycle the DUT
// outputs are compared with a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int PTRWIDTH = 4;
  localparam int LENW     = PTRWIDTH + 1;
  localparam int DEPTH    = 16;

  logic                     wr_clk;
  logic                     wr_rst_n;
  logic [NREQ-1:0]          req;
  logic [NREQ*LENW-1:0]     req_len;
  logic [NREQ*WIDTH-1:0]    req_data;
  logic [NREQ-1:0]          grant;
  logic [NREQ-1:0]          data_rd;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data;
  logic [PTRWIDTH:0]        fifo_usedw;
  logic                     fifo_full;
  logic                     busy;

  int                       len_a  [NREQ];
  logic [WIDTH-1:0]         data_a [NREQ];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which requester owns the port (-1 = none), beats left,
  // whether the trailing gap is in progress, and where the next search starts.
  int m_cur, m_rem, m_rr;
  bit m_gap;

  // Observation of DUT behaviour for directed checks.
  int              n_wr;
  int              n_rd [NREQ];
  int              gq[$];
  logic [NREQ-1:0] prev_grant;

  fifo_wr_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .PTRWIDTH (PTRWIDTH)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rst_n   (wr_rst_n),
    .req        (req),
    .req_len    (req_len),
    .req_data   (req_data),
    .grant      (grant),
    .data_rd    (data_rd),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .fifo_usedw (fifo_usedw),
    .fifo_full  (fifo_full),
    .busy       (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  always_comb begin
    req_len  = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_len[i*LENW +: LENW]   = LENW'(len_a[i]);
      req_data[i*WIDTH +: WIDTH] = data_a[i];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clr_obs();
    n_wr = 0;
    for (int i = 0; i < NREQ; i++) n_rd[i] = 0;
    gq.delete();
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return 1 time unit after the next rising edge for new stimulus.
  task automatic step();
    logic [NREQ-1:0]  e_grant;
    logic             e_wr;
    logic [WIDTH-1:0] e_data;
    int               free;
    int               idx;
    @(negedge wr_clk);
    if (!wr_rst_n) begin
      m_cur = -1; m_rem = 0; m_gap = 1'b0; m_rr = 0;
    end
    e_grant = (m_cur >= 0) ? (NREQ'(1) << m_cur) : '0;
    e_wr    = (m_cur >= 0) && !m_gap && !fifo_full;
    e_data  = (m_cur >= 0) ? data_a[m_cur] : '0;
    check_val("grant",      32'(grant),      32'(e_grant));
    check_val("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    check_val("data_rd",    32'(data_rd),    32'(e_wr ? e_grant : '0));
    check_val("fifo_data",  32'(fifo_data),  32'(e_data));
    check_val("busy",       32'(busy),       32'(m_cur >= 0));

    if (fifo_wr_en) n_wr++;
    for (int i = 0; i < NREQ; i++) if (data_rd[i]) n_rd[i]++;
    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < NREQ; i++) if (grant[i]) gq.push_back(i);
    prev_grant = grant;

    if (wr_rst_n) begin
      if (m_cur < 0) begin
        free = DEPTH - int'(fifo_usedw);
        for (int k = 0; k < NREQ; k++) begin
`ifdef FWA_STRICT_PRIO_EN
          idx = k;
`else
          idx = (m_rr + k) % NREQ;
`endif
          if (m_cur < 0 && req[idx] && len_a[idx] != 0 && len_a[idx] <= free) begin
            m_cur = idx;
            m_rem = len_a[idx];
            m_rr  = (idx + 1) % NREQ;
          end
        end
      end else if (m_gap) begin
        m_cur = -1;
        m_gap = 1'b0;
      end else if (!fifo_full) begin
        m_rem--;
        if (m_rem == 0) m_gap = 1'b1;
      end
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle_inputs();
    req        = '0;
    fifo_full  = 1'b0;
    fifo_usedw = '0;
    for (int i = 0; i < NREQ; i++) begin
      len_a[i]  = 0;
      data_a[i] = 8'(8'h10 * i + 1);
    end
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    wr_rst_n = 1'b1;
    clr_obs();
  endtask

  int exp_fair [5];

  initial begin
    m_cur = -1; m_rem = 0; m_gap = 1'b0; m_rr = 0;
    prev_grant = '0;
    wr_rst_n   = 1'b0;
    idle_inputs();
    clr_obs();
    #1;

    // Reset state and single burst of 5 beats.
    do_reset();
    req = 4'b0001; len_a[0] = 5;
    step();
    req = '0;
    for (int c = 0; c < 8; c++) step();
    check_val("single_wr_beats", 32'(n_wr),       32'd5);
    check_val("single_rd_pulses", 32'(n_rd[0]),   32'd5);
    check_val("single_grants",   32'(gq.size()),  32'd1);
    check_val("single_busy_end", 32'(busy),       32'd0);

    // Space check: 5 beats do not fit at usedw=12, do at usedw=11.
    do_reset();
    fifo_usedw = 5'd12; req = 4'b0010; len_a[1] = 5;
    for (int c = 0; c < 4; c++) step();
    check_val("space_nogrant", 32'(gq.size()), 32'd0);
    fifo_usedw = 5'd11;
    for (int c = 0; c < 3; c++) step();
    check_val("space_grants", 32'(gq.size()), 32'd1);
    check_val("space_who", (gq.size() > 0) ? 32'(gq[0]) : 32'd99, 32'd1);
    req = '0;
    for (int c = 0; c < 8; c++) step();

    // Fairness: every requester always asking for 2 beats.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) len_a[i] = 2;
    for (int c = 0; c < 22; c++) step();
`ifdef FWA_STRICT_PRIO_EN
    exp_fair = '{0, 0, 0, 0, 0};
`else
    exp_fair = '{0, 1, 2, 3, 0};
`endif
    for (int k = 0; k < 5; k++)
      check_val($sformatf("fair_order%0d", k),
                (gq.size() > k) ? 32'(gq[k]) : 32'd99, 32'(exp_fair[k]));
    req = '0;
    for (int c = 0; c < 4; c++) step();

    // Full stall after beat 2 of 4.
    do_reset();
    req = 4'b0001; len_a[0] = 4;
    step();
    step();
    step();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) step();
    fifo_full = 1'b0;
    req = '0;
    for (int c = 0; c < 6; c++) step();
    check_val("stall_wr_beats",  32'(n_wr),    32'd4);
    check_val("stall_rd_pulses", 32'(n_rd[0]), 32'd4);

    // Reset in the middle of a 6-beat burst from requester 1.
    do_reset();
    req = 4'b0010; len_a[1] = 6;
    step();
    step();
    step();
    wr_rst_n = 1'b0;
    #1;
    check_val("rst_mid_grant", 32'(grant),      32'd0);
    check_val("rst_mid_wr_en", 32'(fifo_wr_en), 32'd0);
    check_val("rst_mid_busy",  32'(busy),       32'd0);
    req = 4'b0101; len_a[0] = 1; len_a[1] = 0; len_a[2] = 1;
    step();
    wr_rst_n = 1'b1;
    clr_obs();
    step();
    step();
    check_val("rst_rrptr_first", (gq.size() > 0) ? 32'(gq[0]) : 32'd99, 32'd0);
    req = '0;
    for (int c = 0; c < 4; c++) step();

    // Zero-length request never wins.
    do_reset();
    req = 4'b1100; len_a[2] = 0; len_a[3] = 1;
    for (int c = 0; c < 10; c++) step();
    check_val("zlen_grants", 32'(gq.size() >= 2), 32'd1);
    for (int k = 0; k < gq.size(); k++)
      check_val($sformatf("zlen_who%0d", k), 32'(gq[k]), 32'd3);

    // Two low-index requesters asking for single beats.
    do_reset();
    req = 4'b0011; len_a[0] = 1; len_a[1] = 1;
    for (int c = 0; c < 6; c++) step();
    check_val("pair_first", (gq.size() > 0) ? 32'(gq[0]) : 32'd99, 32'd0);
`ifdef FWA_STRICT_PRIO_EN
    check_val("pair_second", (gq.size() > 1) ? 32'(gq[1]) : 32'd99, 32'd0);
`else
    check_val("pair_second", (gq.size() > 1) ? 32'(gq[1]) : 32'd99, 32'd1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        len_a[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                                : $urandom_range(0, 6);
        data_a[i] = 8'($urandom);
      end
      fifo_usedw = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 16))
                                               : 5'($urandom_range(0, 4));
      fifo_full  = ($urandom_range(0, 9) == 0);
      wr_rst_n   = ($urandom_range(0, 299) != 0);
      step();
    end
    wr_rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
